// File: rtl/sfx_sequencer.sv
// Multi-channel sound-effect sequencer: latches event pulses and plays the highest-priority
// pending melody from parameter ROMs, one note per tick. Build option SFX_PREEMPT_EN enables preemption.
//
// state | meaning
// IDLE  | silent; on tick, start the lowest-index pending event
// PLAY  | sounding notes of active_event, one per tick
// REST  | one silent tick between repeats of the same melody
module sfx_sequencer #(
   parameter int NUM_EVENTS = 4,
   parameter int TONE_W     = 4,
   parameter int MAX_NOTES  = 8,
   parameter int LEN_W      = $clog2(MAX_NOTES + 1),
   parameter int REP_W      = 2,
   parameter logic [NUM_EVENTS*MAX_NOTES*TONE_W-1:0] NOTE_ROM =
      128'h00000006_00000004_79790740_25792229,
   parameter logic [NUM_EVENTS*LEN_W-1:0] LEN_ROM = 16'h1188,
   parameter logic [NUM_EVENTS*REP_W-1:0] REP_ROM = 8'h5A
) (
   input  logic                          clk,
   input  logic                          resetN,
   input  logic                          tick,
   input  logic [NUM_EVENTS-1:0]         event_pulse,
   output logic                          enable_sound,
   output logic [TONE_W-1:0]             tone,
   output logic                          busy,
   output logic [$clog2(NUM_EVENTS)-1:0] active_event,
   output logic                          done
);
   localparam int EV_W  = $clog2(NUM_EVENTS);
   localparam int IDX_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, REST = 2'd2} state_t;

   state_t                state, state_n;
   logic [IDX_W-1:0]      note_idx, note_idx_n;
   logic [REP_W-1:0]      rep_cnt, rep_cnt_n;
   logic [NUM_EVENTS-1:0] pending, clr_mask;
   logic [TONE_W-1:0]     tone_n;
   logic                  enable_n, busy_n, done_n, start;
   logic [EV_W-1:0]       active_n, sel_ev;
   logic                  sel_any;
   logic [LEN_W-1:0]      sel_len, act_len, nxt_idx;
   logic                  more_reps;

   // Length of zero disables the event; oversized lengths clamp to the note table depth.
   function automatic logic [LEN_W-1:0] len_of(input logic [EV_W-1:0] e);
      logic [LEN_W-1:0] l;
      l = LEN_ROM[int'(e)*LEN_W +: LEN_W];
      if (int'(l) > MAX_NOTES) l = LEN_W'(MAX_NOTES);
      return l;
   endfunction

   function automatic logic [REP_W:0] reps_of(input logic [EV_W-1:0] e);
      logic [REP_W-1:0] r;
      r = REP_ROM[int'(e)*REP_W +: REP_W];
      return (r == '0) ? (REP_W+1)'(1) : {1'b0, r};
   endfunction

   function automatic logic [TONE_W-1:0] note_of(input logic [EV_W-1:0] e,
                                                 input logic [IDX_W-1:0] n);
      return NOTE_ROM[(int'(e)*MAX_NOTES + int'(n))*TONE_W +: TONE_W];
   endfunction

   always_comb begin
      sel_any = 1'b0;
      sel_ev  = '0;
      for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_any = 1'b1;
            sel_ev  = EV_W'(i);
         end
      end
   end

   assign sel_len   = len_of(sel_ev);
   assign act_len   = len_of(active_event);
   assign nxt_idx   = LEN_W'(note_idx) + LEN_W'(1);
   assign more_reps = ({1'b0, rep_cnt} + (REP_W+1)'(1)) < reps_of(active_event);

   always_comb begin
      state_n    = state;
      note_idx_n = note_idx;
      rep_cnt_n  = rep_cnt;
      tone_n     = tone;
      enable_n   = enable_sound;
      busy_n     = busy;
      active_n   = active_event;
      done_n     = 1'b0;
      clr_mask   = '0;
      start      = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (sel_any) begin
                  clr_mask[sel_ev] = 1'b1;
                  start            = (sel_len != '0);
               end
            end
            PLAY: begin
               if (nxt_idx < act_len) begin
                  note_idx_n = IDX_W'(nxt_idx);
                  tone_n     = note_of(active_event, IDX_W'(nxt_idx));
               end else if (more_reps) begin
                  state_n  = REST;
                  enable_n = 1'b0;
               end else begin
                  state_n  = IDLE;
                  enable_n = 1'b0;
                  busy_n   = 1'b0;
                  done_n   = 1'b1;
               end
            end
            REST: begin
               state_n    = PLAY;
               note_idx_n = '0;
               tone_n     = note_of(active_event, '0);
               enable_n   = 1'b1;
               rep_cnt_n  = rep_cnt + REP_W'(1);
            end
            default: state_n = IDLE;
         endcase
`ifdef SFX_PREEMPT_EN
         // A disabled (zero-length) higher-priority request is only cleared; play continues.
         if (state != IDLE && sel_any && sel_ev < active_event) begin
            clr_mask[sel_ev] = 1'b1;
            start            = (sel_len != '0);
         end
`endif
         if (start) begin
            state_n    = PLAY;
            note_idx_n = '0;
            rep_cnt_n  = '0;
            tone_n     = note_of(sel_ev, '0);
            enable_n   = 1'b1;
            busy_n     = 1'b1;
            active_n   = sel_ev;
            done_n     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE;
         note_idx     <= '0;
         rep_cnt      <= '0;
         pending      <= '0;
         tone         <= '0;
         enable_sound <= 1'b0;
         busy         <= 1'b0;
         active_event <= '0;
         done         <= 1'b0;
      end else begin
         state        <= state_n;
         note_idx     <= note_idx_n;
         rep_cnt      <= rep_cnt_n;
         // set wins over clear so a pulse for the event being started re-queues it
         pending      <= (pending & ~clr_mask) | event_pulse;
         tone         <= tone_n;
         enable_sound <= enable_n;
         busy         <= busy_n;
         active_event <= active_n;
         done         <= done_n;
      end
   end
endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: two instances (default ROMs, and e2 disabled) share stimulus;
// a melody-expansion reference model queues expected per-tick frames that a monitor checks every cycle.
module tb_sfx_sequencer;
   typedef struct packed {
      logic       en;
      logic [3:0] tone;
      logic       busy;
      logic [1:0] ae;
      logic       done;
   } frame_t;

   logic       clk = 1'b0;
   logic       resetN;
   logic       tick;
   logic [3:0] event_pulse;
   logic       en0, busy0, done0, en1, busy1, done1;
   logic [3:0] tone0, tone1;
   logic [1:0] ae0, ae1;

   int errors = 0;
   int checks = 0;

   int note_tab[4][8] = '{'{9, 2, 2, 2, 9, 7, 5, 2},
                          '{0, 4, 7, 0, 9, 7, 9, 7},
                          '{4, 0, 0, 0, 0, 0, 0, 0},
                          '{6, 0, 0, 0, 0, 0, 0, 0}};
   int len_tab[2][4]  = '{'{8, 8, 1, 1}, '{8, 8, 0, 1}};
   int rep_tab[4]     = '{2, 2, 1, 1};

   logic [3:0] pend[2];
   frame_t     cur[2];
   frame_t     frames[2][$];
   frame_t     exp_q[2][$];
   frame_t     mon_last[2];

   sfx_sequencer u0 (
      .clk(clk), .resetN(resetN), .tick(tick), .event_pulse(event_pulse),
      .enable_sound(en0), .tone(tone0), .busy(busy0), .active_event(ae0), .done(done0)
   );

   sfx_sequencer #(.LEN_ROM(16'h1088)) u1 (
      .clk(clk), .resetN(resetN), .tick(tick), .event_pulse(event_pulse),
      .enable_sound(en1), .tone(tone1), .busy(busy1), .active_event(ae1), .done(done1)
   );

   always #5 clk = ~clk;

   function automatic int lowest(input logic [3:0] p);
      for (int i = 0; i < 4; i++) if (p[i]) return i;
      return 0;
   endfunction

   // Whole sequence as the list of outputs it should show on successive ticks.
   task automatic expand(input int k, input int e);
      int     l, r;
      frame_t f;
      l = (len_tab[k][e] > 8) ? 8 : len_tab[k][e];
      r = (rep_tab[e] == 0) ? 1 : rep_tab[e];
      f = '0;
      f.ae   = 2'(e);
      f.busy = 1'b1;
      for (int rr = 0; rr < r; rr++) begin
         for (int n = 0; n < l; n++) begin
            f.en   = 1'b1;
            f.tone = 4'(note_tab[e][n]);
            frames[k].push_back(f);
         end
         if (rr < r - 1) begin
            f.en = 1'b0;
            frames[k].push_back(f);
         end
      end
      f.en   = 1'b0;
      f.busy = 1'b0;
      f.done = 1'b1;
      frames[k].push_back(f);
   endtask

   task automatic model_edge(input int k, input logic t, input logic [3:0] p);
      logic [3:0] clr;
      frame_t     f;
      int         e;
      clr = '0;
      if (t) begin
         f      = cur[k];
         f.done = 1'b0;
         if (frames[k].size() != 0) begin
`ifdef SFX_PREEMPT_EN
            if (pend[k] != 0 && lowest(pend[k]) < int'(cur[k].ae)) begin
               e      = lowest(pend[k]);
               clr[e] = 1'b1;
               if (len_tab[k][e] != 0) begin
                  frames[k].delete();
                  expand(k, e);
               end
            end
`endif
            f = frames[k].pop_front();
         end else if (pend[k] != 0) begin
            e      = lowest(pend[k]);
            clr[e] = 1'b1;
            if (len_tab[k][e] != 0) begin
               expand(k, e);
               f = frames[k].pop_front();
            end
         end
         exp_q[k].push_back(f);
         cur[k] = f;
      end
      pend[k] = (pend[k] & ~clr) | p;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         pend[k] = '0;
         cur[k]  = '0;
         frames[k].delete();
         exp_q[k].delete();
      end
   endtask

   task automatic cmp(input string name, input int k, input frame_t got, input frame_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t: got en=%0b tone=%0d busy=%0b ae=%0d done=%0b, want en=%0b tone=%0d busy=%0b ae=%0d done=%0b",
                  name, k, $time, got.en, got.tone, got.busy, got.ae, got.done,
                  want.en, want.tone, want.busy, want.ae, want.done);
      end
   endtask

   task automatic cyc(input logic t, input logic [3:0] p);
      @(negedge clk);
      tick        = t;
      event_pulse = p;
      for (int k = 0; k < 2; k++) model_edge(k, t, p);
   endtask

   task automatic run_ticks(input int n);
      repeat (n) begin
         cyc(1'b1, 4'b0000);
         repeat (3) cyc(1'b0, 4'b0000);
      end
   endtask

   // Monitor: pops one expected frame per tick, and checks outputs hold between ticks.
   initial begin
      logic   t_s, r_s;
      frame_t obs, want;
      forever begin
         @(posedge clk);
         t_s = tick;
         r_s = resetN;
         #1;
         for (int k = 0; k < 2; k++) begin
            obs = (k == 0) ? {en0, tone0, busy0, ae0, done0} : {en1, tone1, busy1, ae1, done1};
            if (!r_s || !resetN) begin
               mon_last[k] = '0;
            end else if (t_s) begin
               if (exp_q[k].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL scoreboard_empty dut%0d t=%0t: got no expected frame, want one per tick", k, $time);
               end else begin
                  mon_last[k] = exp_q[k].pop_front();
               end
            end
            want = mon_last[k];
            if (!(t_s && r_s)) want.done = 1'b0;
            cmp(t_s ? "tick_frame" : "hold", k, obs, want);
         end
      end
   end

   initial begin
      frame_t z0, z1;
      resetN      = 1'b0;
      tick        = 1'b0;
      event_pulse = '0;
      model_reset();
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      run_ticks(2);

      cyc(1'b0, 4'b1000);              // e3 between ticks
      run_ticks(4);
      cyc(1'b0, 4'b0010);              // e1 full two-pass melody
      run_ticks(20);
      cyc(1'b0, 4'b1100);              // e2 and e3 together
      run_ticks(6);
      cyc(1'b0, 4'b0010);              // e0 arrives during note 3 of e1
      run_ticks(4);
      cyc(1'b0, 4'b0001);
      run_ticks(40);
      cyc(1'b0, 4'b0100);              // e2 disabled in u1
      run_ticks(4);
      cyc(1'b1, 4'b1000);              // pulse coinciding with a tick
      repeat (3) cyc(1'b0, 4'b0000);
      run_ticks(4);
      cyc(1'b0, 4'b1000);              // re-latch while busy
      run_ticks(1);
      cyc(1'b0, 4'b1000);
      run_ticks(6);

      cyc(1'b0, 4'b0010);              // reset in the middle of e1
      run_ticks(5);
      cyc(1'b0, 4'b0100);
      cyc(1'b0, 4'b0000);
      #2 resetN = 1'b0;
      #1;
      z0 = {en0, tone0, busy0, ae0, done0};
      z1 = {en1, tone1, busy1, ae1, done1};
      cmp("async_reset", 0, z0, '0);
      cmp("async_reset", 1, z1, '0);
      model_reset();
      cyc(1'b0, 4'b0000);
      cyc(1'b0, 4'b0000);
      resetN = 1'b1;
      run_ticks(3);

      for (int i = 0; i < 400; i++) begin
         logic [3:0] p;
         p = '0;
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 15) == 0) p[b] = 1'b1;
         cyc((i % 4) == 0, p);
      end
      run_ticks(60);
      repeat (3) @(negedge clk);

      for (int k = 0; k < 2; k++) begin
         checks++;
         if (exp_q[k].size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain dut%0d: got %0d frames left, want 0", k, exp_q[k].size());
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Parametrised multi-channel sound-effect sequencer for the VGA game top level.
- Accepts NUM_EVENTS single-cycle event pulses (loss, win, coin, wall hit, ...) and latches them as pending requests.
- Plays the highest-priority pending melody from a parameter ROM, one note per tick strobe, driving the existing tone/enable audio path.
- Adds per-event melody length, repeat count, sticky request latching and priority preemption.

Parameters:
- NUM_EVENTS, 4: number of event channels; index 0 is highest priority.
- TONE_W, 4: tone code width.
- MAX_NOTES, 8: maximum notes per melody.
- LEN_W, $clog2(MAX_NOTES+1): width of a length field.
- REP_W, 2: width of a repeat-count field.
- NOTE_ROM, NUM_EVENTS*MAX_NOTES*TONE_W bits: note n of event e at [(e*MAX_NOTES+n)*TONE_W +: TONE_W]. Defaults:
  - e0 = 9,2,2,2,9,7,5,2
  - e1 = 0,4,7,0,9,7,9,7
  - e2 = 4
  - e3 = 6
- LEN_ROM, NUM_EVENTS*LEN_W bits: melody length of event e at [e*LEN_W +: LEN_W]. Defaults 8,8,1,1. A value of 0 disables the event; values above MAX_NOTES are clamped to MAX_NOTES.
- REP_ROM, NUM_EVENTS*REP_W bits: play count of event e at [e*REP_W +: REP_W]. Defaults 2,2,1,1. A value of 0 is treated as 1.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous reset, active-low
- tick  in  1  one-cycle note-step strobe (quarter-second)
- event_pulse  in  NUM_EVENTS  one-cycle request per event
- enable_sound  out  1  sound enable to tone generator
- tone  out  TONE_W  current tone code
- busy  out  1  high while in PLAY or REST
- active_event  out  $clog2(NUM_EVENTS)  index of the sequence being played
- done  out  1  one-cycle pulse when a sequence completes all repeats

Behaviour:
- Reset (asynchronous, resetN low): all outputs 0, pending 0, state IDLE, all counters 0.
- Pending latch:
  - pending[e] is set on any clk edge where event_pulse[e] is high, whether or not tick is high.
  - pending[e] is cleared only when event e is started.
  - Repeated pulses for an already pending event collapse into one request.
- Step timing: state, tone, enable_sound, busy and active_event change only on cycles with tick high. done is the only output that changes outside that rule.
- Pulse latency: a pulse that coincides with a tick is seen on the next tick. Latency from pulse to first note is 1 to 2 tick periods.
- State IDLE, on tick:
  - If pending is non-zero and the selected event has LEN > 0: pick the lowest index e, load note index 0 and repeat count 0, output note 0, set enable_sound=1, busy=1, active_event=e, clear pending[e], go to PLAY.
  - A pending event with LEN=0 is cleared and ignored.
- State PLAY, on tick:
  - Advance the note index. If it is still below LEN, output the next note.
  - At the end of the melody, if the play count is not yet exhausted: go to REST with enable_sound=0, and hold tone.
  - At the end of the last repeat: set enable_sound=0 and busy=0, pulse done for one clk cycle, go to IDLE.
- State REST, on tick: restart at note 0, output it, increment the repeat count, return to PLAY.
- Pulses for active_event while busy re-latch pending, so the sequence replays once afterwards.
- Lower-priority pending requests stay latched and play after the current sequence finishes. Each sequence end returns to IDLE for one tick of silence.
- Counters never wrap. The note index saturates at LEN-1, and the repeat count is compared against the clamped ROM value.

Optional Feature:
- Macro: SFX_PREEMPT_EN.
- Defined:
  - In PLAY or REST, if any pending[e] has e < active_event on a tick, the current sequence is aborted without a done pulse.
  - The new event starts on that same tick: its note 0 is output and its pending bit is cleared.
  - The aborted event is dropped, not resumed.
- Undefined: no preemption; every started sequence plays to completion.

Test Plan:
- Reset mid-PLAY of e1 -> outputs 0 immediately without waiting for a clk edge; busy=0; pending cleared; the next tick stays silent.
- e3 pulse between ticks -> next tick: tone=6, enable=1, active_event=3; following tick: enable=0, done pulse, busy=0.
- e1 pulse (defaults) -> tones 0,4,7,0,9,7,9,7 with enable=1, one REST tick with enable=0, the 8 tones again, then done. busy high for 17 ticks.
- e2 and e3 pulsed in the same cycle -> tone 4 plays, one idle tick, then tone 6. Both done pulses seen.
- SFX_PREEMPT_EN defined: e0 pulsed during note 3 of e1 -> next tick tone=9, active_event=0, no done for e1. Undefined: e1 completes, idle tick, then e0 plays.
- LEN_ROM entry for e2 set to 0 -> e2 pulse produces no sound; pending[e2] clears on the next tick.
